// File: rtl/pn_pkg.sv
// pn_pkg: shared constants and types for the QC-LDPC permutation-network
// control path. The datapath, the sequencer and pn_ctrl_gen all see the same
// circulant size, shift width and stage count from here.
//   Z      : circulant size (data lanes)
//   SW     : shift width, ceil(log2(Z))
//   STAGES : network stages; stage k rotates by 2^k mod Z (equals SW)
package pn_pkg;

    localparam int Z      = 96;
    localparam int SW     = 7;
    localparam int STAGES = 7;

    typedef logic [SW-1:0] shift_t;

    // One slot of the control skew pipeline: a live flag plus the effective
    // shift whose bit k steers stage k.
    typedef struct packed {
        logic   valid;
        shift_t e;
    } pn_token_t;

    // A shift is usable only if it names one of the Z lanes.
    function automatic logic shift_legal(shift_t s);
        return int'(s) < Z;
    endfunction

endpackage

// File: rtl/pn_ctrl_gen_if.sv
// pn_ctrl_gen_if: bundle between the schedule sequencer / switch-unit array
// and pn_ctrl_gen.
//   shift_i, inv_i, in_valid : requested shift, inverse flag, request valid
//   in_ready                 : request accepted when high (= !stall_i)
//   stall_i                  : downstream hold, freezes the whole block
//   launch_o                 : present the lane vector to stage 0 this cycle
//   ctrl_o[k], vld_o[k]      : ctrl bit and live flag for stage k
//   done_o                   : token leaving the last stage this cycle
//   err_o                    : one-cycle pulse, illegal shift dropped
// modport master: the surrounding environment; modport slave: pn_ctrl_gen.
interface pn_ctrl_gen_if;
    import pn_pkg::*;

    shift_t            shift_i;
    logic              inv_i;
    logic              in_valid;
    logic              in_ready;
    logic              stall_i;
    logic              launch_o;
    logic [STAGES-1:0] ctrl_o;
    logic [STAGES-1:0] vld_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output shift_i, inv_i, in_valid, stall_i,
        input  in_ready, launch_o, ctrl_o, vld_o, done_o, err_o
    );

    modport slave (
        input  shift_i, inv_i, in_valid, stall_i,
        output in_ready, launch_o, ctrl_o, vld_o, done_o, err_o
    );

endinterface

// File: rtl/pn_shift_norm.sv
// pn_shift_norm: combinational range check plus inverse-shift computation.
// Shared with the sequencer's self-check so both agree on the mapping.
//   s   : requested shift
//   inv : 1 = return path, use (Z - s) mod Z
//   ok  : s names a real lane (s < Z)
//   e   : effective shift, always < Z when ok is high
module pn_shift_norm
    import pn_pkg::*;
(
    input  shift_t s,
    input  logic   inv,
    output logic   ok,
    output shift_t e
);

    // NOTE: every output gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        ok = shift_legal(s);
        e  = s;
        // s == 0 is its own inverse; Z - 0 would name a non-existent lane.
        if (inv && (s != '0)) begin
            e = shift_t'(Z) - s;
        end
    end

endmodule

// File: rtl/pn_ctrl_gen.sv
// pn_ctrl_gen: control-word generator for the 96-wide QC-LDPC permutation
// network. Accepts one shift per cycle, optionally inverts it, and walks the
// effective shift down a STAGES-deep slot pipeline so that stage k sees bit k
// of its token exactly when the data reaches it.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : pn_ctrl_gen_if.slave (request handshake, stall, per-stage ctrl)
// Flow: accept edge E0 -> input register; E1 -> normalise, load slot 0 or
// raise err; each later unstalled edge moves every slot one stage on.
module pn_ctrl_gen
    import pn_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    pn_ctrl_gen_if.slave  bus
);

    logic      advance;
    logic      in_vld_q;
    shift_t    in_s_q;
    logic      in_inv_q;
    logic      norm_ok;
    shift_t    norm_e;
    logic      err_q;
    pn_token_t slot_in;
    pn_token_t slot [STAGES];

    logic [STAGES-1:0] ctrl_vec;
    logic [STAGES-1:0] vld_vec;

    // A stall freezes every register, so ready is simply its complement.
    assign advance      = !bus.stall_i;
    assign bus.in_ready = advance;

    // Input register: validity is reset, the payload only matters when valid.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its source from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_vld_q <= 1'b0;
        end else if (advance) begin
            in_vld_q <= bus.in_valid;
        end
    end

    // NOTE: payload registers carry no reset; their contents are ignored
    // until the matching valid flag is set, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (advance) begin
            in_s_q   <= bus.shift_i;
            in_inv_q <= bus.inv_i;
        end
    end

    pn_shift_norm u_norm (
        .s   (in_s_q),
        .inv (in_inv_q),
        .ok  (norm_ok),
        .e   (norm_e)
    );

    // An illegal shift becomes an empty slot (a hole) plus the err pulse.
    assign slot_in.valid = in_vld_q && norm_ok;
    assign slot_in.e     = norm_e;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (advance) begin
            err_q <= in_vld_q && !norm_ok;
        end
    end

    // Slot pipeline: slot k feeds stage k, one edge behind slot k-1.
    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        pn_token_t src;

        if (k == 0) begin : g_head
            assign src = slot_in;
        end else begin : g_body
            assign src = slot[k-1];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                slot[k].valid <= 1'b0;
            end else if (advance) begin
                slot[k] <= src;
            end
        end
    end

    // Stage k only needs bit k of its token; idle stages are driven low.
    always_comb begin
        ctrl_vec = '0;
        vld_vec  = '0;
        for (int k = 0; k < STAGES; k++) begin
            vld_vec[k]  = slot[k].valid;
            ctrl_vec[k] = slot[k].valid && slot[k].e[k];
        end
    end

    assign bus.ctrl_o   = ctrl_vec;
    assign bus.vld_o    = vld_vec;
    assign bus.launch_o = slot[0].valid;
    assign bus.done_o   = slot[STAGES-1].valid;
    assign bus.err_o    = err_q;

endmodule
